ask_tx_sequencer: RTL and testbench

- Feeds the 12-bit ASK serializer (parallel load on `new_word`, MSB first, one bit per clk).
- Arbitrates round-robin between two word sources using valid/ready.
- Prefixes every burst with a preamble word.
- Generates the `new_word` load strobe at exact 12-cycle slot boundaries, so the serializer is refilled precisely as its last bit leaves.

---
 rtl/ask_tx_sequencer.sv | 111 +++++++++++
 tb/tb_ask_tx_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ask_tx_sequencer.sv
// Slot sequencer for a WORD_W-bit ASK serializer: round-robin between two valid/ready
// sources, one preamble word at the start of every burst, load strobe on each slot boundary.
module ask_tx_sequencer #(
    parameter int                WORD_W   = 12,
    parameter logic [WORD_W-1:0] PREAMBLE = 12'hAAA
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_word,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_word,
    output logic              req1_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              new_word,
    output logic              busy,
    output logic [3:0]        slot_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WORD_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_slot_cnt;
    logic [3:0]        w_slot_cnt_next;
    logic [WORD_W-1:0] r_word_out;
    logic [WORD_W-1:0] w_word_next;
    logic              r_new_word;
    logic              w_new_word_next;
    logic              r_last_grant;
    logic              w_last_grant_next;

    logic w_decide;
    logic w_pick0;
    logic w_pick1;
    logic w_grant0;
    logic w_grant1;

    // last_grant names the source served most recently; on a tie the other one wins.
    assign w_decide = (r_state != S_IDLE) && (r_slot_cnt == LAST_CNT);
    assign w_pick0  = req0_valid && (!req1_valid || r_last_grant);
    assign w_pick1  = req1_valid && (!req0_valid || !r_last_grant);
    assign w_grant0 = w_decide && enable && w_pick0;
    assign w_grant1 = w_decide && enable && w_pick1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_slot_cnt   <= 4'd0;
            r_word_out   <= '0;
            r_new_word   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_slot_cnt   <= w_slot_cnt_next;
            r_word_out   <= w_word_next;
            r_new_word   <= w_new_word_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_slot_cnt_next   = 4'd0;
        w_word_next       = r_word_out;
        w_new_word_next   = 1'b0;
        w_last_grant_next = r_last_grant;
        case (r_state)
            S_IDLE: begin
                w_word_next = '0;
                if (enable && (req0_valid || req1_valid)) begin
                    w_state_next    = S_PRE;
                    w_word_next     = PREAMBLE;
                    w_new_word_next = 1'b1;
                end
            end
            S_PRE, S_DATA: begin
                if (!w_decide) begin
                    w_slot_cnt_next = r_slot_cnt + 4'd1;
                end else if (w_grant0 || w_grant1) begin
                    w_state_next      = S_DATA;
                    w_word_next       = w_grant1 ? req1_word : req0_word;
                    w_new_word_next   = 1'b1;
                    w_last_grant_next = w_grant1;
                end else begin
                    // No taker: drop to IDLE and feed zeros so the carrier goes off.
                    w_state_next = S_IDLE;
                    w_word_next  = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_word_next  = '0;
            end
        endcase
    end

    always_comb begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        busy       = (r_state != S_IDLE);
        word_out   = r_word_out;
        new_word   = r_new_word;
        slot_cnt   = r_slot_cnt;
    end

endmodule

// File: tb/tb_ask_tx_sequencer.sv
// Bench for ask_tx_sequencer: vector table for the first burst, a load-word scoreboard
// fed by the stimulus, and hand-written sequences for enable, reset and withdrawal cases.
module tb_ask_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        req0_valid = 1'b0;
    logic [11:0] req0_word = 12'h000;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [11:0] req1_word = 12'h000;
    logic        req1_ready;
    logic [11:0] word_out;
    logic        new_word;
    logic        busy;
    logic [3:0]  slot_cnt;

    ask_tx_sequencer #(.WORD_W(12), .PREAMBLE(12'hAAA)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_word  (req0_word),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_word  (req1_word),
        .req1_ready (req1_ready),
        .word_out   (word_out),
        .new_word   (new_word),
        .busy       (busy),
        .slot_cnt   (slot_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [11:0] exp_q[$];
    logic        grant_log[$];
    int          loads_seen = 0;
    int          ready_seen = 0;
    int          gap = 0;
    bit          in_burst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every load strobe pops one expected word; slots inside a burst are 12 apart.
    always @(negedge clk) begin
        if (new_word) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("load_word", word_out, e);
            end
            if (in_burst) chk("slot_gap", gap, 12);
            in_burst = 1'b1;
            gap = 0;
            loads_seen++;
        end else if (!busy) begin
            in_burst = 1'b0;
        end
        gap++;
        if (req0_ready || req1_ready) begin
            ready_seen++;
            grant_log.push_back(req1_ready);
            chk("one_hot_ready", {31'd0, ({req0_ready, req1_ready} != 2'b11)}, 32'd1);
            chk("ready_at_last_cnt", slot_cnt, 4'd11);
        end
    end

    typedef struct {
        int          cyc;
        logic        nw;
        logic [11:0] wo;
        logic        r0;
        logic        bsy;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tv[8];

    initial begin
        int          n;
        int          base;
        int          r;
        logic [23:0] stream;

        tv[0] = '{1,  1'b1, 12'hAAA, 1'b0, 1'b1, 4'd0};
        tv[1] = '{2,  1'b0, 12'hAAA, 1'b0, 1'b1, 4'd1};
        tv[2] = '{11, 1'b0, 12'hAAA, 1'b0, 1'b1, 4'd10};
        tv[3] = '{12, 1'b0, 12'hAAA, 1'b1, 1'b1, 4'd11};
        tv[4] = '{13, 1'b1, 12'h5C3, 1'b0, 1'b1, 4'd0};
        tv[5] = '{24, 1'b0, 12'h5C3, 1'b0, 1'b1, 4'd11};
        tv[6] = '{25, 1'b0, 12'h000, 1'b0, 1'b0, 4'd0};
        tv[7] = '{26, 1'b0, 12'h000, 1'b0, 1'b0, 4'd0};

        // Reset state
        repeat (3) tick();
        chk("reset_state", {new_word, word_out, busy, slot_cnt, req0_ready, req1_ready}, 20'd0);

        // 1: single word from source 0, cycle-exact table plus serial stream
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h5C3);
        reset_n = 1'b1; enable = 1'b1; req0_valid = 1'b1; req0_word = 12'h5C3;
        stream = 24'd0;
        for (int c = 1; c <= 26; c++) begin
            tick();
            for (int k = 0; k < 8; k++) begin
                if (tv[k].cyc == c)
                    chk($sformatf("t1_cyc%0d", c),
                        {new_word, word_out, req0_ready, busy, slot_cnt},
                        {tv[k].nw, tv[k].wo, tv[k].r0, tv[k].bsy, tv[k].cnt});
            end
            if (c <= 24) stream = {stream[22:0], word_out[4'd11 - slot_cnt]};
            if (c == 13) req0_valid = 1'b0;
        end
        chk("t1_serial_stream", stream, 24'hAAA5C3);

        // 2: both sources continuously valid, alternating grants starting with source 0
        reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1;
        exp_q.delete(); grant_log.delete();
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h111); exp_q.push_back(12'h222);
        exp_q.push_back(12'h111); exp_q.push_back(12'h222);
        base = loads_seen;
        req0_word = 12'h111; req1_word = 12'h222;
        req0_valid = 1'b1; req1_valid = 1'b1; enable = 1'b1;
        n = 0;
        while (loads_seen < base + 5 && n < 100) begin tick(); n++; end
        chk("t2_loads_seen", loads_seen - base, 5);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        chk("t2_idle", busy, 1'b0);
        chk("t2_grant_count", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++)
            chk($sformatf("t2_grant%0d", k), grant_log[k], k[0]);

        // 3: single word from source 1, then back to a quiet IDLE
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h9E7);
        req1_word = 12'h9E7; req1_valid = 1'b1;
        n = 0;
        while (!req1_ready && n < 30) begin tick(); n++; end
        chk("t3_ready1_seen", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("t3_data_slot_len", n, 12);
        chk("t3_idle_outputs", {busy, new_word, word_out, slot_cnt}, 18'd0);
        base = loads_seen;
        repeat (5) tick();
        chk("t3_no_loads_idle", loads_seen - base, 0);
        chk("t3_still_zero", {busy, word_out}, 13'd0);

        // 4: enable dropped mid DATA slot; slot completes, no grant, then restart
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h111);
        base = loads_seen;
        req0_word = 12'h111; req1_word = 12'h222;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (loads_seen < base + 2 && n < 40) begin tick(); n++; end
        n = 0;
        while (slot_cnt != 4'd5 && n < 20) begin tick(); n++; end
        chk("t4_at_cnt5", slot_cnt, 4'd5);
        enable = 1'b0;
        r = ready_seen;
        n = 0;
        base = 0;
        while (busy && n < 20) begin base = slot_cnt; tick(); n++; end
        chk("t4_ticks_to_idle", n, 7);
        chk("t4_last_cnt", base, 11);
        chk("t4_no_ready", ready_seen - r, 0);
        chk("t4_queue_drained", exp_q.size(), 0);
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h222);
        base = loads_seen;
        enable = 1'b1;
        n = 0;
        while (loads_seen < base + 2 && n < 40) begin tick(); n++; end
        chk("t4_restart_loads", loads_seen - base, 2);

        // 5: reset at slot_cnt 7 of DATA, then source 0 wins the first contest
        n = 0;
        while (slot_cnt != 4'd7 && n < 20) begin tick(); n++; end
        chk("t5_at_cnt7", {busy, slot_cnt}, {1'b1, 4'd7});
        reset_n = 1'b0;
        tick();
        chk("t5_reset_outputs", {new_word, word_out, busy, slot_cnt, req0_ready, req1_ready}, 20'd0);
        exp_q.delete(); grant_log.delete();
        exp_q.push_back(12'hAAA);
        exp_q.push_back(12'h111);
        base = loads_seen;
        reset_n = 1'b1;
        n = 0;
        while (loads_seen < base + 2 && n < 40) begin tick(); n++; end
        chk("t5_loads", loads_seen - base, 2);
        chk("t5_first_grant_src0", (grant_log.size() > 0) ? {31'd0, grant_log[0]} : 32'hFF, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        chk("t5_idle", busy, 1'b0);

        // 6: requester withdraws during the preamble -> preamble-only burst
        exp_q.push_back(12'hAAA);
        base = loads_seen;
        req0_word = 12'h3C3; req0_valid = 1'b1;
        n = 0;
        while (loads_seen < base + 1 && n < 10) begin tick(); n++; end
        n = 0;
        while (slot_cnt != 4'd3 && n < 20) begin tick(); n++; end
        req0_valid = 1'b0;
        r = ready_seen;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("t6_ticks_to_idle", n, 9);
        chk("t6_no_ready", ready_seen - r, 0);
        chk("t6_only_preamble", loads_seen - base, 1);
        chk("t6_queue_drained", exp_q.size(), 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
